// File: rtl/jt12_pkg.sv
// Shared types and bus-address constants for the JT12 register write sequencer.
package jt12_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    AWAIT,
    DATA,
    DWAIT
  } state_t;

  localparam logic [1:0] ADDR_PHASE = 2'd0;
  localparam logic [1:0] DATA_PHASE = 2'd1;

  typedef struct packed {
    logic       part;
    logic [7:0] regn;
    logic [7:0] val;
  } cmd_t;

  // Chip bus address: bit 1 selects the register part, bit 0 the phase.
  function automatic logic [1:0] bus_addr(input logic part, input logic [1:0] phase);
    return phase | {part, 1'b0};
  endfunction

endpackage

// File: rtl/jt12_wrseq_if.sv
// Command handshake and chip bus signals of the write sequencer.
interface jt12_wrseq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_part;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_val;
  logic [1:0] ym_addr;
  logic [7:0] ym_din;
  logic       ym_write;
  logic       ym_busy;

  modport master (
    output cmd_valid, cmd_part, cmd_reg, cmd_val, ym_busy,
    input  cmd_ready, ym_addr, ym_din, ym_write
  );

  modport slave (
    input  cmd_valid, cmd_part, cmd_reg, cmd_val, ym_busy,
    output cmd_ready, ym_addr, ym_din, ym_write
  );
endinterface

// File: rtl/jt12_cmdfifo.sv
// Command FIFO holding {part,reg,val}; power-of-two depth, wrapping pointers.
module jt12_cmdfifo import jt12_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cmd_t                   din,
  input  logic                   pop,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok)  rp <= rp + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/jt12_wrseq.sv
// Serialises queued register writes onto the YM2612 bus: address phase, busy wait,
// data phase, busy wait; repeated addresses skip the address phase via a one-entry cache.
module jt12_wrseq import jt12_pkg::*; #(
  parameter int DEPTH     = 4,
  parameter int TMO       = 255,
  parameter int SKIP_ADDR = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  jt12_wrseq_if.slave            bus,
  output logic                   idle,
  output logic                   timeout,
  output logic [$clog2(DEPTH):0] level
);
  state_t     state;
  state_t     nxt;
  cmd_t       head;
  cmd_t       hold;
  cmd_t       src;
  logic       empty;
  logic       full;
  logic       pop;
  logic       hit;
  logic       waiting;
  logic       wd_exp;
  logic       wait_done;
  logic       cache_vld;
  logic [8:0] cache;
  logic [7:0] wd;
  logic [1:0] addr_q;
  logic [7:0] din_q;

  jt12_cmdfifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid),
    .din   ({bus.cmd_part, bus.cmd_reg, bus.cmd_val}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.cmd_ready = !full;
  assign hit       = (SKIP_ADDR != 0) && cache_vld && (cache == {head.part, head.regn});
  assign waiting   = (state == AWAIT) || (state == DWAIT);
  assign wd_exp    = waiting && (wd == 8'(TMO - 1));
  // wd is zero only in the first wait cycle, when busy has not risen yet.
  assign wait_done = wd_exp || (waiting && (wd != '0) && !bus.ym_busy);
  // DATA entered from IDLE uses the FIFO head directly; from AWAIT the holding register.
  assign src       = (state == IDLE) ? head : hold;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    pop = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          nxt = hit ? DATA : ADDR;
        end
      end
      ADDR:    nxt = AWAIT;
      AWAIT:   if (wait_done) nxt = DATA;
      DATA:    nxt = DWAIT;
      DWAIT:   if (wait_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      cache     <= '0;
      cache_vld <= 1'b0;
      wd        <= '0;
      timeout   <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      if (pop) hold <= head;
      if (nxt == ADDR) begin
        addr_q <= bus_addr(src.part, ADDR_PHASE);
        din_q  <= src.regn;
      end
      if (nxt == DATA) begin
        addr_q <= bus_addr(src.part, DATA_PHASE);
        din_q  <= src.val;
      end
      if (waiting) wd <= wd + 8'd1;
      else         wd <= '0;
      if (state == ADDR) begin
        cache     <= {hold.part, hold.regn};
        cache_vld <= 1'b1;
      end
      if (wd_exp) begin
        timeout   <= 1'b1;
        cache_vld <= 1'b0;
      end
    end
  end

  assign bus.ym_addr  = addr_q;
  assign bus.ym_din   = din_q;
  assign bus.ym_write = (state == ADDR) || (state == DATA);
  assign idle         = empty && (state == IDLE);
endmodule
